// File: rtl/coh_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coh_arb_pkg
//  Description : Shared types and constants for the coherence request
//                arbiter: FSM state encoding, op encoding and the default
//                address/data widths used by processors and the directory.
//  Revision    : 1.0 - initial release
// ============================================================================
package coh_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DEF_NUM_PROCS   = 4;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 64;

endpackage : coh_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at ptr (wrapping modulo N) and returns the first
//                set request as a one-hot grant plus its index.
//  Ports       : req   [N]  - request vector
//                ptr   [IW] - highest-priority position
//                grant [N]  - one-hot winner (0 when no request)
//                index [IW] - winner index (0 when no request)
//                any        - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    // One extra bit so ptr+k cannot overflow before the modulo fold.
    logic [IW:0] w_pos;
    logic        w_found;

    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!w_found && req[w_pos[IW-1:0]]) begin
                w_found                = 1'b1;
                grant[w_pos[IW-1:0]]   = 1'b1;
                index                  = w_pos[IW-1:0];
            end
        end
    end

    assign any = |req;

endmodule : rr_pick
`default_nettype wire

// File: rtl/coh_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : coh_req_arbiter
//  Description : Shares one directory-controller port among NUM_PROCS
//                processor request streams. Round-robin grant, one
//                transaction in flight, port held until the directory
//                reports done.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                req_valid/op/addr/data       - per-processor requests (flat)
//                req_ack, req_done            - one-hot 1-cycle pulses
//                dir_valid/ready/op/addr/data - directory issue handshake
//                dir_src                      - granted processor index
//                dir_done                     - directory completion
//                busy                         - FSM not idle
//                err_timeout                  - watchdog abort pulse
//  Config      : ARB_TIMEOUT_EN - enables the WAIT_DONE watchdog
//                (TIMEOUT_CYC cycles). Undefined: err_timeout stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module coh_req_arbiter
    import coh_arb_pkg::*;
#(
    parameter int NUM_PROCS   = DEF_NUM_PROCS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PROCS-1:0]          req_valid,
    input  logic [NUM_PROCS-1:0]          req_op,
    input  logic [NUM_PROCS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PROCS*DATA_W-1:0]   req_data,
    output logic [NUM_PROCS-1:0]          req_ack,
    output logic [NUM_PROCS-1:0]          req_done,
    output logic                          dir_valid,
    input  logic                          dir_ready,
    output logic                          dir_op,
    output logic [ADDR_W-1:0]             dir_addr,
    output logic [DATA_W-1:0]             dir_data,
    output logic [$clog2(NUM_PROCS)-1:0]  dir_src,
    input  logic                          dir_done,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int SRC_W = $clog2(NUM_PROCS);

    arb_state_t             r_state, w_state_nxt;
    logic [SRC_W-1:0]       r_rr_ptr;
    logic [SRC_W-1:0]       r_src;
    logic                   r_op;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;
    logic [NUM_PROCS-1:0]   r_ack;
    logic [NUM_PROCS-1:0]   r_done;
    logic                   r_err;

    logic [NUM_PROCS-1:0]   w_grant;
    logic [SRC_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_wd_expire;
    logic [NUM_PROCS-1:0]   w_src_onehot;
    logic [SRC_W-1:0]       w_ptr_next;

    rr_pick #(
        .N  (NUM_PROCS),
        .IW (SRC_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .index (w_idx),
        .any   (w_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd_cnt;

    // Counter holds the number of completed WAIT_DONE cycles; expiry fires on
    // the edge that closes the TIMEOUT_CYC-th cycle.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT_DONE)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_expire = (r_state == ST_WAIT_DONE) &&
                         (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign w_wd_expire        = 1'b0;
`endif

    assign w_src_onehot = NUM_PROCS'(1) << r_src;
    assign w_ptr_next   = (r_src == SRC_W'(NUM_PROCS - 1)) ? '0 : r_src + 1'b1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // dir_done here is deliberately ignored.
                if (dir_ready) w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (dir_done || w_wd_expire) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, pulses and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_src    <= '0;
            r_op     <= OP_READ;
            r_addr   <= '0;
            r_data   <= '0;
            r_ack    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_src  <= w_idx;
                        r_op   <= req_op[w_idx];
                        r_addr <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_data <= req_data[int'(w_idx)*DATA_W +: DATA_W];
                        r_ack  <= w_grant;
                    end
                end
                ST_WAIT_DONE: begin
                    // dir_done on the expiry edge counts as a normal completion.
                    if (dir_done || w_wd_expire) begin
                        r_done   <= w_src_onehot;
                        r_rr_ptr <= w_ptr_next;
                        r_err    <= !dir_done;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: directory fields read as zero while idle; read data is
    // forced to zero so undriven write data never reaches the directory.
    // ------------------------------------------------------------------
    assign busy        = (r_state != ST_IDLE);
    assign dir_valid   = (r_state == ST_ISSUE);
    assign dir_op      = busy & r_op;
    assign dir_addr    = busy ? r_addr : '0;
    assign dir_data    = (busy && (r_op == OP_WRITE)) ? r_data : '0;
    assign dir_src     = busy ? r_src : '0;
    assign req_ack     = r_ack;
    assign req_done    = r_done;
    assign err_timeout = r_err;

endmodule : coh_req_arbiter
`default_nettype wire
